// File: rtl/ir_fetch_buffer.sv
// Instruction fetch front end: owns the fetch PC, keeps one I-cache read in flight,
// and queues fetched {pc, instr} pairs in a small circular FIFO for the IQ.
module ir_fetch_buffer #(
   parameter int               DEPTH    = 4,
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h60000000,
   parameter int               PC_STEP  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       instr_read,
   output logic [XLEN-1:0]            instr_mem_address,
   input  logic                       instr_mem_resp,
   input  logic [XLEN-1:0]            in,
   input  logic                       redirect,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       out_valid,
   output logic [XLEN-1:0]            out_instr,
   output logic [XLEN-1:0]            out_pc,
   input  logic                       out_ack,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]       state_reg, state_next;
   logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
   logic [XLEN-1:0]  drain_addr_reg;
   logic [PW-1:0]    head_reg, tail_reg;
   logic [CW-1:0]    count_reg, count_next;
   logic [XLEN-1:0]  pc_mem_reg    [DEPTH];
   logic [XLEN-1:0]  instr_mem_reg [DEPTH];
   logic [DEPTH-1:0] wr_en;
   logic             push, pop;

   assign push      = (state_reg == FETCH) && instr_mem_resp && !redirect;
   assign out_valid = (count_reg != '0) && !redirect;
   assign pop       = out_valid && out_ack;

   assign instr_read        = (state_reg == FETCH) || (state_reg == DRAIN);
   // While draining, the I-cache still expects the address of the abandoned read.
   assign instr_mem_address = (state_reg == DRAIN) ? drain_addr_reg : fetch_pc_reg;

   assign out_instr = instr_mem_reg[head_reg];
   assign out_pc    = pc_mem_reg[head_reg];
   assign count     = count_reg;

   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      case (state_reg)
         IDLE: begin
            if (redirect)
               fetch_pc_next = redirect_pc;
            else if (count_reg < CW'(DEPTH))
               state_next = FETCH;
         end
         FETCH: begin
            if (instr_mem_resp) begin
               state_next    = IDLE;
               fetch_pc_next = redirect ? redirect_pc : fetch_pc_reg + XLEN'(PC_STEP);
            end else if (redirect) begin
               state_next    = DRAIN;
               fetch_pc_next = redirect_pc;
            end
         end
         DRAIN: begin
            if (redirect)
               fetch_pc_next = redirect_pc;
            if (instr_mem_resp)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      count_next = count_reg;
      if (redirect)
         count_next = '0;
      else if (push && !pop)
         count_next = count_reg + CW'(1);
      else if (pop && !push)
         count_next = count_reg - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         fetch_pc_reg   <= RESET_PC;
         drain_addr_reg <= RESET_PC;
         head_reg       <= '0;
         tail_reg       <= '0;
         count_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         count_reg    <= count_next;
         if (state_reg == FETCH)
            drain_addr_reg <= fetch_pc_reg;
         if (redirect) begin
            head_reg <= '0;
            tail_reg <= '0;
         end else begin
            if (pop)
               head_reg <= head_reg + PW'(1);
            if (push)
               tail_reg <= tail_reg + PW'(1);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = push && (tail_reg == PW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst) begin
            pc_mem_reg[i]    <= '0;
            instr_mem_reg[i] <= '0;
         end else if (wr_en[i]) begin
            pc_mem_reg[i]    <= fetch_pc_reg;
            instr_mem_reg[i] <= in;
         end
      end
   end

   // A fetch only starts with a free slot and count cannot rise mid-read.
   no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && count_reg == CW'(DEPTH)));

endmodule
